// File: rtl/sdf_delay_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: delay-line gating, butterfly select, output framing.
// Optional SDF_CTRL_ERR_EN adds the err port and aborts a frame on a misaligned in_eop.
module sdf_delay_ctrl #(
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(2*DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_sop,
  input  logic in_eop,
  output logic in_ready,
  output logic shift_en,
  output logic sel,
  output logic out_valid,
`ifdef SDF_CTRL_ERR_EN
  output logic out_sop,
  output logic err
`else
  output logic out_sop
`endif
);

  localparam int FCNT_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_FILL_END = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(2*DEPTH - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST    = FCNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [FCNT_W-1:0] fcnt, fcnt_nxt;
  logic              first_blk, first_blk_nxt;
  logic              accept, run_acc, blk_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      fcnt      <= '0;
      first_blk <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      fcnt      <= fcnt_nxt;
      first_blk <= first_blk_nxt;
    end
  end

  always_comb begin
    in_ready      = (state != FLUSH);
    accept        = in_valid & in_ready;
    run_acc       = accept & (state == RUN);
    blk_end       = (cnt == CNT_LAST);
    shift_en      = 1'b0;
    sel           = 1'b0;
    out_valid     = run_acc | (state == FLUSH);
    out_sop       = run_acc & first_blk & (cnt == CNT_HALF);
    state_nxt     = state;
    cnt_nxt       = cnt;
    fcnt_nxt      = fcnt;
    first_blk_nxt = first_blk;

    case (state)
      IDLE: begin
        // Samples arriving before a start-of-frame never touch the delay line.
        shift_en = accept & in_sop;
        if (accept && in_sop) begin
          state_nxt     = FILL;
          cnt_nxt       = CNT_W'(1);
          first_blk_nxt = 1'b1;
        end
      end
      FILL: begin
        shift_en = accept;
        sel      = cnt[CNT_W-1];
        if (accept) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_FILL_END) state_nxt = RUN;
        end
      end
      RUN: begin
        shift_en = accept;
        sel      = cnt[CNT_W-1];
        if (accept) begin
          cnt_nxt = cnt + 1'b1;
          if (blk_end) first_blk_nxt = 1'b0;
          if (in_eop && blk_end) begin
            state_nxt = FLUSH;
            fcnt_nxt  = '0;
          end
`ifdef SDF_CTRL_ERR_EN
          else if (in_eop) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
`endif
        end
      end
      FLUSH: begin
        // Drain the last DEPTH differences out of the delay line.
        shift_en = 1'b1;
        fcnt_nxt = fcnt + 1'b1;
        if (fcnt == FCNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SDF_CTRL_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= run_acc & in_eop & ~blk_end;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_sdf_delay_ctrl.sv
// Randomised scoreboard bench for sdf_delay_ctrl (DEPTH=4); honours SDF_CTRL_ERR_EN when defined.
module tb_sdf_delay_ctrl;
  localparam int DEPTH = 4;
  localparam int M_IDLE = 0, M_FRAME = 1, M_FLUSH = 2;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_sop, in_eop;
  logic in_ready, shift_en, sel, out_valid, out_sop;
`ifdef SDF_CTRL_ERR_EN
  logic err;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: frame phase, sample index within frame, flush cycle count.
  int  mode = M_IDLE;
  int  k = 0;
  int  fl = 0;
  bit  err_due = 0;
  logic [2:0] q[$];

  sdf_delay_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready), .shift_en(shift_en), .sel(sel),
    .out_valid(out_valid),
`ifdef SDF_CTRL_ERR_EN
    .out_sop(out_sop),
    .err(err)
`else
    .out_sop(out_sop)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: every cycle the stage shifts or emits, pop one expected event.
  always @(negedge clk) begin
    if (!rst && (shift_en || out_valid || out_sop)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event t=%0t got shift=%b sel=%b ov=%b sop=%b, required no activity",
                 $time, shift_en, sel, out_valid, out_sop);
      end else begin
        logic [2:0] e;
        e = q.pop_front();
        if ({shift_en, sel, out_valid, out_sop} !== {1'b1, e}) begin
          errors++;
          $display("FAIL event t=%0t got shift/sel/ov/sop=%b, required %b",
                   $time, {shift_en, sel, out_valid, out_sop}, {1'b1, e});
        end
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t got %b, required %b", name, $time, act, req);
    end
  endtask

  // One clock cycle of stimulus; the model predicts whether the sample is taken.
  task automatic step(input logic v, input logic s, input logic e, output bit acc);
    bit exp_rdy, exp_err;
    @(posedge clk); #1;
    in_valid = v; in_sop = s; in_eop = e;
    exp_rdy = (mode != M_FLUSH);
    exp_err = err_due;
    err_due = 0;
    acc = 0;
    case (mode)
      M_FLUSH: begin
        q.push_back(3'b010);
        fl++;
        if (fl == DEPTH) mode = M_IDLE;
      end
      M_IDLE: if (v && s) begin
        q.push_back(3'b000);
        mode = M_FRAME;
        k = 1;
        acc = 1;
      end
      default: if (v) begin
        acc = 1;
        q.push_back({((k / DEPTH) % 2) == 1, k >= DEPTH, k == DEPTH});
        if (e && k >= DEPTH) begin
          if (k % (2*DEPTH) == 2*DEPTH - 1) begin
            mode = M_FLUSH;
            fl = 0;
          end
`ifdef SDF_CTRL_ERR_EN
          else begin
            err_due = 1;
            mode = M_IDLE;
          end
`endif
        end
        k++;
      end
    endcase
    @(negedge clk);
    chk("in_ready", in_ready, exp_rdy);
`ifdef SDF_CTRL_ERR_EN
    chk("err", err, exp_err);
`else
    if (exp_err) chk("err_model", 1'b1, 1'b0);
`endif
  endtask

  // One frame of len samples; optional stall gap, random stalls and misaligned eop.
  task automatic frame(input int len, input int bad_eop, input int stall_at,
                       input int stall_n, input bit rnd);
    bit acc;
    for (int i = 0; i < len; i++) begin
      if (i == stall_at) repeat (stall_n) step(0, 0, 0, acc);
      if (rnd && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) step(0, 1'($urandom), 1'($urandom), acc);
      do step(1, i == 0 || (rnd && i > 0 && $urandom_range(0, 7) == 0),
              i == len - 1 || i == bad_eop, acc);
      while (!acc);
      if (i > 0 && mode == M_IDLE) break;
    end
  endtask

  task automatic drain();
    bit acc;
    for (int n = 0; n < 4*DEPTH && mode != M_IDLE; n++) step(0, 0, 0, acc);
    step(0, 0, 0, acc);
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_shift_en"}, shift_en, 1'b0);
    chk({tag, "_sel"}, sel, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_sop"}, out_sop, 1'b0);
`ifdef SDF_CTRL_ERR_EN
    chk({tag, "_err"}, err, 1'b0);
`endif
  endtask

  initial begin
    bit acc;
    rst = 1'b1; in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0;
    #1;
    reset_values("reset");
    @(posedge clk); #2; rst = 1'b0;

    // Directed: plain frame, stalled frame, idle junk, misaligned eop.
    frame(16, -1, -1, 0, 0);
    drain();
    frame(16, -1, 6, 2, 0);
    drain();
    repeat (3) step(1, 0, 0, acc);
    frame(16, 6, -1, 0, 0);
    drain();

    // Asynchronous reset in RUN with cnt = 5, then a clean frame.
    for (int i = 0; i < 5; i++) step(1, i == 0, 0, acc);
    @(posedge clk); #1;
    in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0;
    rst = 1'b1;
    #1;
    reset_values("midreset");
    chk("midreset_queue_empty", q.size() == 0, 1'b1);
    mode = M_IDLE; err_due = 0;
    @(posedge clk); #2; rst = 1'b0;
    frame(16, -1, -1, 0, 0);
    drain();

    // Back-to-back short frames: second sop held through the flush.
    frame(8, -1, -1, 0, 0);
    frame(8, -1, -1, 0, 0);
    drain();

    // Randomised frames with stalls, idle junk and occasional misaligned eop.
    for (int f = 0; f < 30; f++) begin
      int len, bad;
      len = 2*DEPTH * $urandom_range(1, 3);
      bad = -1;
      if ($urandom_range(0, 3) == 0) begin
        bad = $urandom_range(DEPTH, len - 2);
        if (bad % (2*DEPTH) == 2*DEPTH - 1) bad = -1;
      end
      repeat ($urandom_range(0, 2)) step(1'($urandom), 1'b0, 1'($urandom), acc);
      frame(len, bad, -1, 0, 1);
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events got %0d pending, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
